camera_capture: RTL

CAMERA_CAPTURE -- requirements
Module: camera_capture

---
 rtl/camera_pkg.sv | 7 +
 rtl/camera_capture_if.sv | 29 ++
 rtl/pixel_packer.sv | 38 +++
 rtl/camera_capture.sv | 81 ++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// camera_pkg: capture FSM states and default sensor geometry shared by the capture block
package camera_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_VS_HIGH, WAIT_VS_LOW, CAPTURE} cap_state_t;
  localparam int DEF_BYTES_PER_PIXEL = 2;
  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_V_LINES = 480;
endpackage

// File: rtl/camera_capture_if.sv
// camera_capture_if: sensor-side inputs and pixel/status outputs of camera_capture
interface camera_capture_if
  import camera_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES = DEF_V_LINES
);
  logic vsync_in;
  logic href_in;
  logic [7:0] p_data_in;
  logic arm_in;
  logic continuous_in;
  logic [8*BYTES_PER_PIXEL-1:0] pixel_data_out;
  logic pixel_valid_out;
  logic [$clog2(H_PIXELS+1)-1:0] hcount_out;
  logic [$clog2(V_LINES+1)-1:0] vcount_out;
  logic frame_done_out;
  logic busy_out;
  logic size_err_out;
  modport master (
    output vsync_in, href_in, p_data_in, arm_in, continuous_in,
    input pixel_data_out, pixel_valid_out, hcount_out, vcount_out, frame_done_out, busy_out, size_err_out
  );
  modport slave (
    input vsync_in, href_in, p_data_in, arm_in, continuous_in,
    output pixel_data_out, pixel_valid_out, hcount_out, vcount_out, frame_done_out, busy_out, size_err_out
  );
endinterface

// File: rtl/pixel_packer.sv
// pixel_packer: collects BYTES_PER_PIXEL sensor bytes MSB-first and strobes the finished pixel
module pixel_packer #(
  parameter int BYTES_PER_PIXEL = 2
) (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic en,
  input logic [7:0] data,
  output logic [8*BYTES_PER_PIXEL-1:0] pixel,
  output logic valid,
  output logic last
);
  localparam int IW = BYTES_PER_PIXEL > 1 ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_PIXEL - 1);
  logic [IW-1:0] idx;
  logic [8*BYTES_PER_PIXEL-1:0] shift, merged;
  assign last = en && idx == LAST_IDX;
  // the incoming byte lands in its lane so the final byte completes the pixel combinationally
  always_comb begin
    merged = shift;
    merged[8*(BYTES_PER_PIXEL-1-int'(idx)) +: 8] = data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
      shift <= '0;
      pixel <= '0;
      valid <= 1'b0;
    end else begin
      valid <= last;
      if (last) pixel <= merged;
      if (en) shift <= merged;
      if (clear || last) idx <= '0;
      else if (en) idx <= idx + 1'b1;
    end
  end
endmodule

// File: rtl/camera_capture.sv
// camera_capture: armed single/continuous frame grabber for a vsync/href byte-serial sensor
module camera_capture
  import camera_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES = DEF_V_LINES
) (
  input logic p_clock_in,
  input logic rst_in,
  camera_capture_if.slave cam
);
  localparam int HW = $clog2(H_PIXELS + 1);
  localparam int VW = $clog2(V_LINES + 1);
  localparam logic [HW-1:0] H_MAX = HW'(H_PIXELS);
  localparam logic [VW-1:0] V_MAX = VW'(V_LINES);
  cap_state_t state;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic href_d, capturing, store, fall, last;
  // vsync overrides href: a byte arriving with vsync high is never stored
  assign capturing = state == CAPTURE && !cam.vsync_in;
  assign store = capturing && cam.href_in;
  assign fall = capturing && href_d && !cam.href_in;
  assign cam.busy_out = state != IDLE;
  pixel_packer #(.BYTES_PER_PIXEL(BYTES_PER_PIXEL)) u_packer (
    .clk(p_clock_in),
    .rst(rst_in),
    .clear(!capturing || fall),
    .en(store),
    .data(cam.p_data_in),
    .pixel(cam.pixel_data_out),
    .valid(cam.pixel_valid_out),
    .last(last)
  );
  always_ff @(posedge p_clock_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      hcount <= '0;
      vcount <= '0;
      href_d <= 1'b0;
      cam.hcount_out <= '0;
      cam.vcount_out <= '0;
      cam.frame_done_out <= 1'b0;
      cam.size_err_out <= 1'b0;
    end else begin
      href_d <= store;
      cam.frame_done_out <= 1'b0;
      if (last) begin
        cam.hcount_out <= hcount;
        cam.vcount_out <= vcount;
        hcount <= hcount == H_MAX ? H_MAX : hcount + 1'b1;
      end
      case (state)
        IDLE:
          if (cam.arm_in) begin
            state <= WAIT_VS_HIGH;
            cam.size_err_out <= 1'b0;
          end
        WAIT_VS_HIGH: if (cam.vsync_in) state <= WAIT_VS_LOW;
        WAIT_VS_LOW:
          if (!cam.vsync_in) begin
            state <= CAPTURE;
            hcount <= '0;
            vcount <= '0;
          end
        CAPTURE:
          if (cam.vsync_in) begin
            cam.frame_done_out <= 1'b1;
            if (vcount != V_MAX) cam.size_err_out <= 1'b1;
            state <= cam.continuous_in ? WAIT_VS_LOW : IDLE;
          end else if (fall) begin
            hcount <= '0;
            vcount <= vcount == V_MAX ? V_MAX : vcount + 1'b1;
            if (hcount != H_MAX) cam.size_err_out <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
